// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the multicycle FSM and the datapath
interface multicycle_control_if;
  // Instruction fields and status from the datapath
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  // Control outputs toward the datapath
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALU_control;
  logic       Illegal;

  // Datapath side: supplies instruction fields/status, consumes controls
  modport master (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU_control, Illegal
  );

  // Controller side
  modport slave (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU_control, Illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I-subset control FSM
module multicycle_control (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.slave   bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state_q, state_d;

  logic       is_lw, is_sw, is_r, is_i, is_beq, is_jal;
  logic [2:0] alu_dec;
  logic       alu_f3_ok;
  logic       decode_bad;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  // Opcode classification, funct3-driven ALU decode and legality check
  always_comb begin
    is_lw  = (bus.op == OP_LW);
    is_sw  = (bus.op == OP_SW);
    is_r   = (bus.op == OP_R);
    is_i   = (bus.op == OP_I);
    is_beq = (bus.op == OP_BEQ);
    is_jal = (bus.op == OP_JAL);

    alu_dec   = ALU_ADD;
    alu_f3_ok = 1'b1;
    case (bus.funct3)
      3'b000:  alu_dec = (is_r && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_f3_ok = 1'b0;
    endcase

    decode_bad = !(is_lw || is_sw || is_jal ||
                   ((is_r || is_i) && alu_f3_ok) ||
                   (is_beq && (bus.funct3 == 3'b000)));

    // Immediate format depends only on the opcode, not on the state
    imm_src = 2'b00;
    if (is_sw)       imm_src = 2'b01;
    else if (is_beq) imm_src = 2'b10;
    else if (is_jal) imm_src = 2'b11;
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (decode_bad) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_r)               state_d = S_EXECUTER;
        else if (is_i)               state_d = S_EXECUTEI;
        else if (is_beq)             state_d = S_BEQ;
        else                         state_d = S_JAL;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = is_sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.MemReady) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = bus.Zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State register; reset parks the FSM in FETCH without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Enables and Illegal are held off for as long as reset is asserted,
  // since FETCH would otherwise raise IRWrite/PCWrite on MemReady.
  assign bus.PCWrite     = pc_write  & rst_n;
  assign bus.IRWrite     = ir_write  & rst_n;
  assign bus.MemWrite    = mem_write & rst_n;
  assign bus.RegWrite    = reg_write & rst_n;
  assign bus.Illegal     = illegal   & rst_n;
  assign bus.AdrSrc      = adr_src;
  assign bus.ResultSrc   = result_src;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ImmSrc      = imm_src;
  assign bus.ALU_control = alu_control;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ctl_t  exp_q[$];
  string name_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  logic [1:0] cur_imm;

  ctl_t act;
  assign act = '{pcw: bus.PCWrite, adr: bus.AdrSrc, memw: bus.MemWrite,
                 irw: bus.IRWrite, regw: bus.RegWrite, res: bus.ResultSrc,
                 sa: bus.ALUSrcA, sb: bus.ALUSrcB, imm: bus.ImmSrc,
                 alu: bus.ALU_control, ill: bus.Illegal};

  // Monitor: every cycle the DUT presents a control word; compare it with the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_total++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %05h (pcw%b adr%b mw%b irw%b rw%b res%b sa%b sb%b imm%b alu%b ill%b) required %05h",
                    nm, act, act.pcw, act.adr, act.memw, act.irw, act.regw, act.res,
                    act.sa, act.sb, act.imm, act.alu, act.ill, e);
    end
  end

  // Hand-written expected control words, one per FSM state
  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t c = '0;
    c.pcw = rdy; c.irw = rdy; c.sb = 2'b10; c.res = 2'b10;
    return c;
  endfunction
  function automatic ctl_t e_decode(input logic ill);
    ctl_t c = '0;
    c.sa = 2'b01; c.sb = 2'b01; c.ill = ill;
    return c;
  endfunction
  function automatic ctl_t e_memadr();
    ctl_t c = '0;
    c.sa = 2'b10; c.sb = 2'b01;
    return c;
  endfunction
  function automatic ctl_t e_memread();
    ctl_t c = '0;
    c.adr = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_memwb();
    ctl_t c = '0;
    c.res = 2'b01; c.regw = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_memwrite();
    ctl_t c = '0;
    c.adr = 1'b1; c.memw = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_exec(input logic rtype, input logic [2:0] alu);
    ctl_t c = '0;
    c.sa = 2'b10; c.sb = rtype ? 2'b00 : 2'b01; c.alu = alu;
    return c;
  endfunction
  function automatic ctl_t e_aluwb();
    ctl_t c = '0;
    c.regw = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_beq(input logic z);
    ctl_t c = '0;
    c.sa = 2'b10; c.alu = 3'b001; c.pcw = z;
    return c;
  endfunction
  function automatic ctl_t e_jal();
    ctl_t c = '0;
    c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1;
    return c;
  endfunction

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [1:0] imm);
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; cur_imm = imm;
  endtask

  // One clock: drive inputs, queue the expectation, advance past the next rising edge
  task automatic cyc(input logic rdy, input logic z, input ctl_t e, input string nm);
    bus.MemReady = rdy;
    bus.Zero     = z;
    e.imm        = cur_imm;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input string nm, input logic rtype, input logic [2:0] alu);
    cyc(1'b1, 1'b0, e_fetch(1'b1), {nm, "_fetch"});
    cyc(1'b0, 1'b0, e_decode(1'b0), {nm, "_decode"});
    cyc(1'b0, 1'b1, e_exec(rtype, alu), {nm, "_exec"});
    cyc(1'b0, 1'b0, e_aluwb(), {nm, "_aluwb"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.MemReady = 1'b1;
    bus.Zero = 1'b0;
    instr(7'b0110011, 3'b000, 1'b0, 2'b00);
    @(posedge clk); #1;
    // Reset held with MemReady high: FETCH outputs but no enables
    cyc(1'b1, 1'b0, e_fetch(1'b0), "reset_hold");
    rst_n = 1'b1;

    // add, sub, slti (funct7b5 set), addi (funct7b5 set, must stay ADD), or, and
    run_alu("add", 1'b1, 3'b000);
    instr(7'b0110011, 3'b000, 1'b1, 2'b00);
    run_alu("sub", 1'b1, 3'b001);
    instr(7'b0010011, 3'b010, 1'b1, 2'b00);
    run_alu("slti", 1'b0, 3'b101);
    instr(7'b0010011, 3'b000, 1'b1, 2'b00);
    run_alu("addi_f7", 1'b0, 3'b000);
    instr(7'b0110011, 3'b110, 1'b0, 2'b00);
    run_alu("or", 1'b1, 3'b011);
    instr(7'b0010011, 3'b111, 1'b0, 2'b00);
    run_alu("andi", 1'b0, 3'b010);

    // beq taken then not taken
    instr(7'b1100011, 3'b000, 1'b0, 2'b10);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "beq1_fetch");
    cyc(1'b1, 1'b0, e_decode(1'b0), "beq1_decode");
    cyc(1'b1, 1'b1, e_beq(1'b1), "beq1_taken");
    cyc(1'b1, 1'b1, e_fetch(1'b1), "beq2_fetch");
    cyc(1'b1, 1'b1, e_decode(1'b0), "beq2_decode");
    cyc(1'b1, 1'b0, e_beq(1'b0), "beq2_not_taken");

    // lw: 2 stalls in FETCH, 3 in MEMREAD, 10 cycles total
    instr(7'b0000011, 3'b010, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_wait0");
    cyc(1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_wait1");
    cyc(1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
    cyc(1'b0, 1'b0, e_decode(1'b0), "lw_decode");
    cyc(1'b0, 1'b0, e_memadr(), "lw_memadr");
    cyc(1'b0, 1'b0, e_memread(), "lw_memread_wait0");
    cyc(1'b0, 1'b0, e_memread(), "lw_memread_wait1");
    cyc(1'b0, 1'b0, e_memread(), "lw_memread_wait2");
    cyc(1'b1, 1'b0, e_memread(), "lw_memread");
    cyc(1'b0, 1'b0, e_memwb(), "lw_memwb");

    // sw: MemWrite held for 3 cycles
    instr(7'b0100011, 3'b010, 1'b0, 2'b01);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
    cyc(1'b1, 1'b0, e_decode(1'b0), "sw_decode");
    cyc(1'b1, 1'b0, e_memadr(), "sw_memadr");
    cyc(1'b0, 1'b0, e_memwrite(), "sw_memwrite_wait0");
    cyc(1'b0, 1'b0, e_memwrite(), "sw_memwrite_wait1");
    cyc(1'b1, 1'b0, e_memwrite(), "sw_memwrite");

    // jal
    instr(7'b1101111, 3'b000, 1'b0, 2'b11);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "jal_fetch");
    cyc(1'b1, 1'b0, e_decode(1'b0), "jal_decode");
    cyc(1'b1, 1'b0, e_jal(), "jal_jal");
    cyc(1'b1, 1'b0, e_aluwb(), "jal_aluwb");

    // Illegal opcode, then illegal funct3 for R-type and beq
    instr(7'b1111111, 3'b000, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "ill_op_fetch");
    cyc(1'b1, 1'b0, e_decode(1'b1), "ill_op_decode");
    instr(7'b0110011, 3'b001, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "ill_r_fetch");
    cyc(1'b1, 1'b0, e_decode(1'b1), "ill_r_decode");
    instr(7'b1100011, 3'b001, 1'b0, 2'b10);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "ill_beq_fetch");
    cyc(1'b1, 1'b0, e_decode(1'b1), "ill_beq_decode");

    // lw interrupted by reset during MEMREAD: immediate FETCH, no MEMWB
    instr(7'b0000011, 3'b010, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, e_fetch(1'b1), "lwr_fetch");
    cyc(1'b1, 1'b0, e_decode(1'b0), "lwr_decode");
    cyc(1'b1, 1'b0, e_memadr(), "lwr_memadr");
    cyc(1'b0, 1'b0, e_memread(), "lwr_memread_wait");
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, e_fetch(1'b0), "lwr_async_reset");
    cyc(1'b1, 1'b0, e_fetch(1'b0), "lwr_reset_hold");
    rst_n = 1'b1;
    instr(7'b0110011, 3'b000, 1'b0, 2'b00);
    run_alu("post_reset_add", 1'b1, 3'b000);

    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
